// File: rtl/dmem_access_unit.sv
// MEM-stage requester for the word-wide data memory: byte-addressed loads and stores,
// lane extraction/extension on loads, read-modify-write for sub-word stores.
module dmem_access_unit #(
  parameter int MEM_WORDS   = 512,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData,
  output logic        regRead,
  output logic        regWrite
);

  typedef enum logic [3:0] {
    IDLE,
    ERR,
    RD,
    RD_WAIT,
    WR,
    RMW_RD,
    RMW_WAIT,
    RMW_WR,
    RESP
  } stateT;

  localparam logic [2:0]  latencyInit   = 3'(MEM_LATENCY);
  localparam logic [30:0] memWordsLimit = 31'(MEM_WORDS);

  stateT       state;
  stateT       nextState;
  logic [2:0]  cnt;
  logic [1:0]  sizeReg;
  logic        unsignedReg;
  logic [1:0]  offReg;
  logic [15:0] storeReg;
  logic        misaligned;
  logic        outOfRange;
  logic        reqErr;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic [31:0] loadValue;
  logic [31:0] mergedWord;

  // Request legality is judged on the raw inputs so the accept edge can branch straight to ERR.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    outOfRange = ({1'b0, req_addr[31:2]} >= memWordsLimit);
    reqErr     = misaligned | outOfRange;
  end

  // Little-endian lane handling for both the load result and the store merge.
  always_comb begin
    laneByte  = readData[{offReg, 3'b000} +: 8];
    laneHalf  = offReg[1] ? readData[31:16] : readData[15:0];
    loadValue = readData;
    case (sizeReg)
      2'd0:    loadValue = unsignedReg ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
      2'd1:    loadValue = unsignedReg ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
      default: loadValue = readData;
    endcase
    mergedWord = readData;
    if (sizeReg == 2'd0) begin
      mergedWord[{offReg, 3'b000} +: 8] = storeReg[7:0];
    end else begin
      mergedWord[{offReg[1], 4'b0000} +: 16] = storeReg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    regRead    = 1'b0;
    regWrite   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (reqErr) begin
            nextState = ERR;
          end else if (!req_write) begin
            nextState = RD;
          end else if (req_size == 2'd2) begin
            nextState = WR;
          end else begin
            nextState = RMW_RD;
          end
        end
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        nextState  = IDLE;
      end
      RD: begin
        regRead   = 1'b1;
        nextState = RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt == 3'd1) nextState = RESP;
      end
      WR: begin
        regWrite  = 1'b1;
        nextState = RESP;
      end
      RMW_RD: begin
        regRead   = 1'b1;
        nextState = RMW_WAIT;
      end
      RMW_WAIT: begin
        if (cnt == 3'd1) nextState = RMW_WR;
      end
      RMW_WR: begin
        regWrite  = 1'b1;
        nextState = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture, latency countdown, and the sampling of readData when the count expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 3'd0;
      sizeReg     <= 2'd0;
      unsignedReg <= 1'b0;
      offReg      <= 2'd0;
      storeReg    <= 16'h0;
      resp_rdata  <= 32'h0;
      address     <= 32'h0;
      writeData   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sizeReg     <= req_size;
            unsignedReg <= req_unsigned;
            offReg      <= req_addr[1:0];
            storeReg    <= req_wdata[15:0];
            resp_rdata  <= 32'h0;
            if (!reqErr) begin
              address <= {2'b00, req_addr[31:2]};
              if (req_write && (req_size == 2'd2)) writeData <= req_wdata;
            end
          end
        end
        RD, RMW_RD: cnt <= latencyInit;
        RD_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) resp_rdata <= loadValue;
        end
        RMW_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) writeData <= mergedWord;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed steps and random traffic scored against an array
// model of memory; a second instance with three-cycle memory latency covers reset aborts.
module tb_dmem_access_unit;

  localparam int LAT    = 1;
  localparam int WINDOW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy, regRead, regWrite;
  logic [31:0] resp_rdata, address, writeData, readData;

  dmem_access_unit #(.MEM_WORDS(512), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .address(address),
    .writeData(writeData), .readData(readData), .regRead(regRead), .regWrite(regWrite)
  );

  logic        sReset, sValid, sWrite, sUnsigned;
  logic [1:0]  sSize;
  logic [31:0] sAddr, sWdata;
  logic        sReady, sRespValid, sRespErr, sBusy, sRegRead, sRegWrite;
  logic [31:0] sRdata, sAddress, sWriteData, sReadData;

  dmem_access_unit #(.MEM_WORDS(512), .MEM_LATENCY(3)) dutSlow (
    .clk(clk), .reset(sReset), .req_valid(sValid), .req_ready(sReady),
    .req_write(sWrite), .req_size(sSize), .req_unsigned(sUnsigned),
    .req_addr(sAddr), .req_wdata(sWdata), .resp_valid(sRespValid),
    .resp_rdata(sRdata), .resp_err(sRespErr), .busy(sBusy), .address(sAddress),
    .writeData(sWriteData), .readData(sReadData), .regRead(sRegRead), .regWrite(sRegWrite)
  );

  // Main memory: synchronous read, data valid the cycle after the read strobe.
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (regWrite) mem[address[8:0]] <= writeData;
    if (regRead) readData <= mem[address[8:0]];
  end

  // Slow memory returns a fixed pattern of the word index three edges after the strobe.
  logic [31:0] slowPipe [3];
  always @(posedge clk) begin
    slowPipe[0] <= sRegRead ? (32'hA500_0000 | sAddress) : 32'h0;
    slowPipe[1] <= slowPipe[0];
    slowPipe[2] <= slowPipe[1];
  end
  assign sReadData = slowPipe[2];

  logic sWriteSeen = 1'b0;
  always @(posedge clk) if (sRegWrite) sWriteSeen <= 1'b1;

  int readCount = 0, writeCount = 0, overlapCount = 0;
  logic [31:0] lastWriteData, lastWriteAddr, lastReadAddr;
  always @(negedge clk) begin
    if (regRead) begin
      readCount    = readCount + 1;
      lastReadAddr = address;
    end
    if (regWrite) begin
      writeCount    = writeCount + 1;
      lastWriteData = writeData;
      lastWriteAddr = address;
    end
    if (regRead && regWrite) overlapCount = overlapCount + 1;
  end

  int compared = 0, mismatched = 0;
  logic [31:0] refMem [WINDOW];
  int obsCycles, obsReads, obsWrites, slowCycles, respSeen;
  logic [31:0] lastRdata, slowRdata;
  logic lastErr;
  logic [31:0] bpAddr [3];
  logic [1:0]  bpSize [3];
  logic        bpUns [3];
  logic [31:0] bpExp [3];
  int bpIdx, bpPulses, bpAccepts;
  logic prevResp, willAccept;
  logic rw, ru;
  logic [1:0] rsz;
  logic [31:0] ra;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic modelErr(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b1;
    return (a / 32'd4) >= 32'd512;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] sz, input logic u, input logic [31:0] a);
    int unsigned word, bits, value;
    word = refMem[(a / 4) % WINDOW];
    if (sz == 2'd2) return word;
    bits  = 8 << sz;
    value = (word >> (8 * (a % 4))) % (32'd1 << bits);
    if (!u && value >= (32'd1 << (bits - 1))) value = value - (32'd1 << bits);
    return value;
  endfunction

  task automatic modelStore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned shift, mask;
    shift = 8 * (a % 4);
    mask  = (sz == 2'd2) ? 32'hFFFF_FFFF : (((32'd1 << (8 << sz)) - 1) << shift);
    refMem[(a / 4) % WINDOW] = (refMem[(a / 4) % WINDOW] & ~mask) | ((wd << shift) & mask);
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd);
    int guard, rd0, wr0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("readyBeforeReq", 32'(req_ready), 32'd1);
    rd0 = readCount;
    wr0 = writeCount;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr  = a;    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    obsCycles = 1;
    while (!resp_valid && obsCycles < 40) begin
      @(negedge clk);
      obsCycles++;
    end
    lastRdata = resp_rdata;
    lastErr   = resp_err;
    checkOutput("busyAtResp", 32'(busy), 32'd1);
    checkOutput("readyAtResp", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("respOnePulse", 32'(resp_valid), 32'd0);
    checkOutput("readyAfterResp", 32'(req_ready), 32'd1);
    obsReads  = readCount - rd0;
    obsWrites = writeCount - wr0;
  endtask

  task automatic doAccess(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic expErr, expRead;
    int expCycles;
    logic [31:0] expRdata;
    expErr   = modelErr(sz, a);
    expRdata = (expErr || w) ? 32'h0 : modelLoad(sz, u, a);
    expRead  = !expErr && (!w || sz != 2'd2);
    if (expErr) expCycles = 1;
    else if (!w) expCycles = LAT + 2;
    else if (sz == 2'd2) expCycles = 2;
    else expCycles = LAT + 3;
    applyStimulus(w, sz, u, a, wd);
    checkOutput({tag, ".err"}, 32'(lastErr), 32'(expErr));
    checkOutput({tag, ".rdata"}, lastRdata, expRdata);
    checkOutput({tag, ".cycles"}, 32'(obsCycles), 32'(expCycles));
    checkOutput({tag, ".reads"}, 32'(obsReads), 32'(expRead));
    checkOutput({tag, ".writes"}, 32'(obsWrites), 32'(!expErr && w));
    if (expRead) checkOutput({tag, ".raddr"}, lastReadAddr, a / 4);
    if (!expErr && w) begin
      modelStore(sz, a, wd);
      checkOutput({tag, ".wdata"}, lastWriteData, refMem[(a / 4) % WINDOW]);
      checkOutput({tag, ".waddr"}, lastWriteAddr, a / 4);
    end
  endtask

  task automatic checkSlowIdle(input string tag);
    checkOutput({tag, ".ready"}, 32'(sReady), 32'd1);
    checkOutput({tag, ".respValid"}, 32'(sRespValid), 32'd0);
    checkOutput({tag, ".respErr"}, 32'(sRespErr), 32'd0);
    checkOutput({tag, ".busy"}, 32'(sBusy), 32'd0);
    checkOutput({tag, ".regRead"}, 32'(sRegRead), 32'd0);
    checkOutput({tag, ".regWrite"}, 32'(sRegWrite), 32'd0);
    checkOutput({tag, ".rdata"}, sRdata, 32'd0);
    checkOutput({tag, ".address"}, sAddress, 32'd0);
    checkOutput({tag, ".writeData"}, sWriteData, 32'd0);
  endtask

  task automatic applySlow(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input int resetAt);
    sValid = 1'b1; sWrite = w; sSize = sz; sUnsigned = u; sAddr = a; sWdata = wd;
    @(negedge clk);
    sValid = 1'b0;
    slowCycles = 1;
    if (resetAt > 0) begin
      repeat (resetAt - 1) @(negedge clk);
      sReset = 1'b1;
      @(negedge clk);
      sReset = 1'b0;
      checkSlowIdle("slowAbort");
      respSeen = 0;
      repeat (8) begin
        @(negedge clk);
        if (sRespValid) respSeen++;
      end
      checkOutput("slowAbort.noResp", 32'(respSeen), 32'd0);
    end else begin
      while (!sRespValid && slowCycles < 40) begin
        @(negedge clk);
        slowCycles++;
      end
      slowRdata = sRdata;
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    sReset = 1'b1; sValid = 1'b0; sWrite = 1'b0; sSize = 2'd0; sUnsigned = 1'b0;
    sAddr = 32'h0; sWdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset.ready", 32'(req_ready), 32'd1);
    checkOutput("reset.respValid", 32'(resp_valid), 32'd0);
    checkOutput("reset.respErr", 32'(resp_err), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.regRead", 32'(regRead), 32'd0);
    checkOutput("reset.regWrite", 32'(regWrite), 32'd0);
    checkOutput("reset.rdata", resp_rdata, 32'd0);
    checkOutput("reset.address", address, 32'd0);
    checkOutput("reset.writeData", writeData, 32'd0);
    checkSlowIdle("slowReset");
    reset = 1'b0;
    sReset = 1'b0;
    @(negedge clk);

    $display("[TB] word store then load");
    for (int i = 0; i < WINDOW; i++) refMem[i] = 32'h0;
    doAccess(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, "sw10");
    checkOutput("sw10.const", lastWriteData, 32'hDEADBEEF);
    checkOutput("sw10.addrConst", lastWriteAddr, 32'd4);
    doAccess(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10");
    checkOutput("lw10.const", lastRdata, 32'hDEADBEEF);

    $display("[TB] preload window");
    for (int i = 0; i < WINDOW; i++) doAccess(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, "preload");

    $display("[TB] byte and halfword loads");
    doAccess(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, "sw80");
    doAccess(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lb13");
    checkOutput("lb13.const", lastRdata, 32'hFFFFFF80);
    doAccess(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lbu13");
    checkOutput("lbu13.const", lastRdata, 32'h00000080);
    doAccess(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, "lh12");
    checkOutput("lh12.const", lastRdata, 32'hFFFF80FF);
    doAccess(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, "lhu10");
    checkOutput("lhu10.const", lastRdata, 32'h00007F01);

    $display("[TB] sub-word stores");
    doAccess(1'b1, 2'd2, 1'b0, 32'h08, 32'h11223344, "sw08");
    doAccess(1'b1, 2'd0, 1'b0, 32'h09, 32'h000000AA, "sb09");
    checkOutput("sb09.const", lastWriteData, 32'h1122AA44);
    doAccess(1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000BEEF, "sh0A");
    checkOutput("sh0A.const", lastWriteData, 32'hBEEFAA44);

    $display("[TB] error requests");
    doAccess(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, "errLh03");
    doAccess(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, "errLw02");
    doAccess(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, "errSize3");
    doAccess(1'b0, 2'd2, 1'b0, 32'h800, 32'h0, "errLw800");
    doAccess(1'b1, 2'd2, 1'b0, 32'h800, 32'h12345678, "errSw800");

    $display("[TB] backpressure with valid held high");
    bpAddr = '{32'h10, 32'h09, 32'h0A};
    bpSize = '{2'd2, 2'd0, 2'd1};
    bpUns  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) bpExp[i] = modelLoad(bpSize[i], bpUns[i], bpAddr[i]);
    bpIdx = 0; bpPulses = 0; bpAccepts = 0; prevResp = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = bpSize[0]; req_unsigned = bpUns[0];
    req_addr = bpAddr[0]; req_wdata = 32'h0;
    for (int cyc = 0; cyc < 80 && bpPulses < 3; cyc++) begin
      if (resp_valid) begin
        checkOutput("bp.busy", 32'(busy), 32'd1);
        checkOutput("bp.width", 32'(prevResp), 32'd0);
        checkOutput("bp.rdata", resp_rdata, bpExp[bpPulses]);
        bpPulses++;
      end
      prevResp = resp_valid;
      willAccept = req_valid && req_ready;
      @(negedge clk);
      if (willAccept) begin
        bpAccepts++;
        checkOutput("bp.acceptBusy", 32'(busy), 32'd1);
        checkOutput("bp.acceptReadyLow", 32'(req_ready), 32'd0);
        bpIdx++;
        if (bpIdx < 3) begin
          req_size = bpSize[bpIdx]; req_unsigned = bpUns[bpIdx]; req_addr = bpAddr[bpIdx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    checkOutput("bp.lastWidth", 32'(resp_valid), 32'd0);
    checkOutput("bp.pulses", 32'(bpPulses), 32'd3);
    checkOutput("bp.accepts", 32'(bpAccepts), 32'd3);
    @(negedge clk);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      rw  = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      ru  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        ra = 32'h800 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
      else
        ra = 32'($urandom_range(0, WINDOW - 1)) * 4 + 32'($urandom_range(0, 3));
      doAccess(rw, rsz, ru, ra, $urandom, "rand");
    end
    checkOutput("strobeOverlap", 32'(overlapCount), 32'd0);

    $display("[TB] three-cycle latency instance");
    applySlow(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 3);
    applySlow(1'b1, 2'd0, 1'b0, 32'h41, 32'h5A, 3);
    checkOutput("slowAbort.noWrite", 32'(sWriteSeen), 32'd0);
    applySlow(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
    checkOutput("slowLw.cycles", 32'(slowCycles), 32'd5);
    checkOutput("slowLw.rdata", slowRdata, 32'hA5000010);
    applySlow(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 0);
    checkOutput("slowLb.cycles", 32'(slowCycles), 32'd5);
    checkOutput("slowLb.rdata", slowRdata, 32'hFFFFFFA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage requester for the word-wide data memory; it is the initiator side of the memory's address/writeData/readData/regRead/regWrite interface.
- Accepts byte-addressed load/store requests from the pipeline and converts each byte address to a word index.
- Loads: sign- or zero-extends byte/halfword results.
- Sub-word stores: performs read-modify-write, because the memory has no byte enables.
- Misaligned and out-of-range requests complete with an error flag and never touch memory.

Parameters:
- MEM_WORDS, 512, data memory depth in 32-bit words; word index >= MEM_WORDS is out of range.
- MEM_LATENCY, 1, cycles from a regRead cycle to the edge at which mem_readData is valid and sampled (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as misaligned.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte/halfword taken from low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned or out of range.
- busy  output  1  high from accept through the resp_valid cycle; pipeline stall source.
- address  output  32  word index to data memory (req_addr >> 2).
- writeData  output  32  full word to data memory.
- readData  input  32  word from data memory.
- regRead  output  1  memory read strobe.
- regWrite  output  1  memory write strobe.

Behaviour:
- Reset, synchronous: state = IDLE; resp_valid, resp_err, regRead, regWrite, busy = 0; resp_rdata, address, writeData = 0; latency counter = 0.
- Reset mid-operation aborts without a response. A pending regWrite is deasserted at that edge; a merged word not yet written is never written.
- Accept on a rising edge with req_valid && req_ready. All request fields are registered; inputs are ignored while busy.
- Error check at accept:
  - misaligned when (size 1 && addr[0]), (size 2 && addr[1:0] != 0), or size 3;
  - out of range when addr[31:2] >= MEM_WORDS.
- States:
  - IDLE: on accept, go to ERR if error; else RD if load; WR if word store; RMW_RD if byte/halfword store.
  - ERR: resp_valid = 1, resp_err = 1, rdata = 0; then IDLE. Response appears one cycle after accept.
  - RD: regRead = 1 for exactly one cycle with address driven; counter loads MEM_LATENCY; go to RD_WAIT.
  - RD_WAIT: count down; at the edge where the counter expires, sample readData, extract the lane and extend into resp_rdata; then RESP.
  - RESP: resp_valid = 1 for one cycle; then IDLE.
  - WR: regWrite = 1 for exactly one cycle, writeData = req_wdata; then RESP.
  - RMW_RD: same as RD, but the sampled word goes to a merge register; then RMW_WR.
  - RMW_WR: writeData = sampled word with the addressed lane replaced; regWrite = 1 for one cycle; then RESP.
- Lane rules (little-endian):
  - byte offset k occupies bits [8k+7:8k];
  - a halfword at offset 0 occupies [15:0]; at offset 2 it occupies [31:16].
- Cycle counts, from the accept edge to resp_valid high:
  - error: 1 cycle;
  - load: MEM_LATENCY + 2 cycles;
  - word store: 2 cycles;
  - sub-word store: MEM_LATENCY + 3 cycles.
- regRead and regWrite are never high in the same cycle. address is held stable throughout RD/WR/RMW states.
- req_ready is low from the accept edge through the RESP/ERR cycle. It rises in the cycle after resp_valid, so back-to-back requests incur one idle cycle.

Test Plan:
- Reset while in RD_WAIT (MEM_LATENCY = 3) -> next cycle: all outputs 0, req_ready = 1, no resp_valid, no regWrite ever seen.
- Word store then load, MEM_LATENCY = 1: sw 0xDEADBEEF to addr 0x10 -> regWrite pulse with address 4 and writeData 0xDEADBEEF, resp_valid 2 cycles after accept. lw from 0x10 -> resp_rdata 0xDEADBEEF, resp_valid 3 cycles after accept.
- Signed and unsigned byte loads, memory word 0x80FF7F01 at index 4:
  - lb 0x13 -> 0xFFFFFF80;
  - lbu 0x13 -> 0x00000080;
  - lh 0x12 -> 0xFFFF80FF;
  - lhu 0x10 -> 0x00007F01.
- Sub-word store, word 0x11223344 at index 2: sb 0xAA to 0x09 -> exactly one regRead then one regWrite with writeData 0x1122AA44. Then sh 0xBEEF to 0x0A -> 0xBEEFAA44.
- Errors, each with resp_err = 1 one cycle after accept and no regRead/regWrite:
  - lh at 0x03;
  - lw at 0x02;
  - req_size = 3;
  - lw at 0x800 (index 512).
- Backpressure: hold req_valid high with 3 queued requests -> each is accepted only when req_ready = 1, busy stays high through each resp_valid, and resp_valid pulses exactly 3 times, each one cycle wide.
